// File: rtl/vga_scan_gen.sv
// 640x480@60 raster generator with delayed syncs, divider-free scaled
// source coordinates, ROM address and frame markers.
module vga_scan_gen #(
   parameter int H_VIS      = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_VIS      = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter int SRC_W      = 110,
   parameter int SRC_H      = 96,
   parameter int ADDR_W     = 14,
   parameter int SYNC_DELAY = 2
) (
   input  logic              vga_clk,
   input  logic              reset_n,
   output logic [9:0]        DrawX,
   output logic [9:0]        DrawY,
   output logic              blank,
   output logic              hs,
   output logic              vs,
   output logic [9:0]        src_x,
   output logic [9:0]        src_y,
   output logic [ADDR_W-1:0] rom_addr,
   output logic              frame_start,
   output logic [15:0]       frame_count
);

   localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int AXW   = $clog2(H_VIS + SRC_W);
   localparam int AYW   = $clog2(V_VIS + SRC_H);

   localparam logic [9:0] H_LAST  = 10'(H_TOT - 1);
   localparam logic [9:0] V_LAST  = 10'(V_TOT - 1);
   localparam logic [9:0] H_VIS_C = 10'(H_VIS);
   localparam logic [9:0] V_VIS_C = 10'(V_VIS);
   localparam logic [9:0] HS_ON   = 10'(H_VIS + H_FP);
   localparam logic [9:0] HS_OFF  = 10'(H_VIS + H_FP + H_SYNC);
   localparam logic [9:0] VS_ON   = 10'(V_VIS + V_FP);
   localparam logic [9:0] VS_OFF  = 10'(V_VIS + V_FP + V_SYNC);

   localparam logic [AXW-1:0]    SW_X = AXW'(SRC_W);
   localparam logic [AXW-1:0]    HV_X = AXW'(H_VIS);
   localparam logic [AYW-1:0]    SH_Y = AYW'(SRC_H);
   localparam logic [AYW-1:0]    VV_Y = AYW'(V_VIS);
   localparam logic [ADDR_W-1:0] SW_A = ADDR_W'(SRC_W);

   logic [9:0]        x_q, x_d;
   logic [9:0]        y_q, y_d;
   logic [AXW-1:0]    acc_x_q, acc_x_d;
   logic [AYW-1:0]    acc_y_q, acc_y_d;
   logic [9:0]        src_x_q, src_x_d;
   logic [9:0]        src_y_q, src_y_d;
   logic [ADDR_W-1:0] row_base_q, row_base_d;
   logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
   logic [15:0]       frame_cnt_q, frame_cnt_d;

   logic           eol;
   logic           eof;
   logic           nxt_vis;
   logic [AXW-1:0] t_x;
   logic [AYW-1:0] t_y;
   logic           hs_raw;
   logic           vs_raw;

   always_comb begin
      eol         = (x_q == H_LAST);
      eof         = eol && (y_q == V_LAST);
      x_d         = eol ? 10'd0 : x_q + 10'd1;
      y_d         = y_q;
      frame_cnt_d = frame_cnt_q;
      if (eol) begin
         y_d = eof ? 10'd0 : y_q + 10'd1;
      end
      if (eof) begin
         frame_cnt_d = frame_cnt_q + 16'd1;
      end

      // horizontal step: acc_x tracks (DrawX*SRC_W) mod H_VIS
      t_x     = acc_x_q + SW_X;
      acc_x_d = '0;
      src_x_d = '0;
      if (x_d != 10'd0 && x_d < H_VIS_C && y_d < V_VIS_C) begin
         if (t_x >= HV_X) begin
            acc_x_d = t_x - HV_X;
            src_x_d = src_x_q + 10'd1;
         end else begin
            acc_x_d = t_x;
            src_x_d = src_x_q;
         end
      end

      t_y        = acc_y_q + SH_Y;
      acc_y_d    = acc_y_q;
      src_y_d    = src_y_q;
      row_base_d = row_base_q;
      if (eol) begin
         if (y_d == 10'd0 || y_d >= V_VIS_C) begin
            acc_y_d    = '0;
            src_y_d    = '0;
            row_base_d = '0;
         end else if (t_y >= VV_Y) begin
            acc_y_d    = t_y - VV_Y;
            src_y_d    = src_y_q + 10'd1;
            row_base_d = row_base_q + SW_A;
         end else begin
            acc_y_d = t_y;
         end
      end

      nxt_vis    = (x_d < H_VIS_C) && (y_d < V_VIS_C);
      rom_addr_d = '0;
      if (nxt_vis) begin
         rom_addr_d = row_base_d + ADDR_W'(src_x_d);
      end
   end

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         x_q         <= '0;
         y_q         <= '0;
         acc_x_q     <= '0;
         acc_y_q     <= '0;
         src_x_q     <= '0;
         src_y_q     <= '0;
         row_base_q  <= '0;
         rom_addr_q  <= '0;
         frame_cnt_q <= '0;
      end else begin
         x_q         <= x_d;
         y_q         <= y_d;
         acc_x_q     <= acc_x_d;
         acc_y_q     <= acc_y_d;
         src_x_q     <= src_x_d;
         src_y_q     <= src_y_d;
         row_base_q  <= row_base_d;
         rom_addr_q  <= rom_addr_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   always_comb begin
      hs_raw = !((x_q >= HS_ON) && (x_q < HS_OFF));
      vs_raw = !((y_q >= VS_ON) && (y_q < VS_OFF));
   end

   // syncs lag the counters to line up with the ROM + colour register
   generate
      if (SYNC_DELAY == 0) begin : g_nodly
         assign hs = hs_raw;
         assign vs = vs_raw;
      end else begin : g_dly
         logic [SYNC_DELAY-1:0] hs_dly_q, hs_dly_d;
         logic [SYNC_DELAY-1:0] vs_dly_q, vs_dly_d;

         always_comb begin
            hs_dly_d    = hs_dly_q;
            vs_dly_d    = vs_dly_q;
            hs_dly_d[0] = hs_raw;
            vs_dly_d[0] = vs_raw;
            for (int i = 1; i < SYNC_DELAY; i++) begin
               hs_dly_d[i] = hs_dly_q[i-1];
               vs_dly_d[i] = vs_dly_q[i-1];
            end
         end

         always_ff @(posedge vga_clk or negedge reset_n) begin
            if (!reset_n) begin
               hs_dly_q <= '1;
               vs_dly_q <= '1;
            end else begin
               hs_dly_q <= hs_dly_d;
               vs_dly_q <= vs_dly_d;
            end
         end

         assign hs = hs_dly_q[SYNC_DELAY-1];
         assign vs = vs_dly_q[SYNC_DELAY-1];
      end
   endgenerate

   assign DrawX       = x_q;
   assign DrawY       = y_q;
   assign blank       = (x_q < H_VIS_C) && (y_q < V_VIS_C);
   assign frame_start = (x_q == 10'd0) && (y_q == 10'd0);
   assign src_x       = src_x_q;
   assign src_y       = src_y_q;
   assign rom_addr    = rom_addr_q;
   assign frame_count = frame_cnt_q;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Bench for vga_scan_gen: full-size and shrunken-geometry instances
// compared each cycle against an arithmetic raster model.
module tb_vga_scan_gen;

   typedef struct {
      int hv, hfp, hsy, hbp;
      int vv, vfp, vsy, vbp;
      int sw, sh, sd;
   } cfg_t;

   typedef struct {
      int x, y, bl, hs, vs, sx, sy, ad, fs, fc;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a, rst_b;
   logic [9:0]  xa, ya, sxa, sya, xb, yb, sxb, syb;
   logic        bla, hsa, vsa, fsa, blb, hsb, vsb, fsb;
   logic [13:0] ada;
   logic [9:0]  adb;
   logic [15:0] fca, fcb;

   int checks = 0;
   int errors = 0;
   int na, nb;
   cfg_t ca, cb;

   vga_scan_gen dut_a (
      .vga_clk(clk), .reset_n(rst_a),
      .DrawX(xa), .DrawY(ya), .blank(bla), .hs(hsa), .vs(vsa),
      .src_x(sxa), .src_y(sya), .rom_addr(ada),
      .frame_start(fsa), .frame_count(fca)
   );

   vga_scan_gen #(
      .H_VIS(64), .H_FP(6), .H_SYNC(10), .H_BP(8),
      .V_VIS(40), .V_FP(3), .V_SYNC(2), .V_BP(5),
      .SRC_W(23), .SRC_H(17), .ADDR_W(10), .SYNC_DELAY(3)
   ) dut_b (
      .vga_clk(clk), .reset_n(rst_b),
      .DrawX(xb), .DrawY(yb), .blank(blb), .hs(hsb), .vs(vsb),
      .src_x(sxb), .src_y(syb), .rom_addr(adb),
      .frame_start(fsb), .frame_count(fcb)
   );

   // expected outputs n clock edges after reset release
   function automatic exp_t model(cfg_t c, int n);
      exp_t e;
      int htot, vtot, ftot, p, m, mp, mx, my;
      htot = c.hv + c.hfp + c.hsy + c.hbp;
      vtot = c.vv + c.vfp + c.vsy + c.vbp;
      ftot = htot * vtot;
      p    = n % ftot;
      e.x  = p % htot;
      e.y  = p / htot;
      e.bl = (e.x < c.hv && e.y < c.vv) ? 1 : 0;
      e.sy = (e.y < c.vv) ? (e.y * c.sh) / c.vv : 0;
      e.sx = e.bl ? (e.x * c.sw) / c.hv : 0;
      e.ad = e.bl ? e.sy * c.sw + e.sx : 0;
      e.fs = (p == 0) ? 1 : 0;
      e.fc = (n / ftot) % 65536;
      m    = n - c.sd;
      if (m < 0) begin
         e.hs = 1;
         e.vs = 1;
      end else begin
         mp   = m % ftot;
         mx   = mp % htot;
         my   = mp / htot;
         e.hs = (mx >= c.hv + c.hfp && mx < c.hv + c.hfp + c.hsy) ? 0 : 1;
         e.vs = (my >= c.vv + c.vfp && my < c.vv + c.vfp + c.vsy) ? 0 : 1;
      end
      return e;
   endfunction

   task automatic chk(string tag, logic [31:0] got, int exp);
      checks++;
      if (got !== 32'(exp)) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cmp(string id, cfg_t c, int n,
                      logic [31:0] x, logic [31:0] y, logic [31:0] bl,
                      logic [31:0] h, logic [31:0] v, logic [31:0] sx,
                      logic [31:0] sy, logic [31:0] ad, logic [31:0] fs,
                      logic [31:0] fc);
      exp_t e;
      e = model(c, n);
      chk($sformatf("%s.DrawX@%0d", id, n), x, e.x);
      chk($sformatf("%s.DrawY@%0d", id, n), y, e.y);
      chk($sformatf("%s.blank@%0d", id, n), bl, e.bl);
      chk($sformatf("%s.hs@%0d", id, n), h, e.hs);
      chk($sformatf("%s.vs@%0d", id, n), v, e.vs);
      chk($sformatf("%s.src_x@%0d", id, n), sx, e.sx);
      chk($sformatf("%s.src_y@%0d", id, n), sy, e.sy);
      chk($sformatf("%s.rom_addr@%0d", id, n), ad, e.ad);
      chk($sformatf("%s.frame_start@%0d", id, n), fs, e.fs);
      chk($sformatf("%s.frame_count@%0d", id, n), fc, e.fc);
   endtask

   task automatic cmp_a();
      cmp("A", ca, na, 32'(xa), 32'(ya), 32'(bla), 32'(hsa), 32'(vsa),
          32'(sxa), 32'(sya), 32'(ada), 32'(fsa), 32'(fca));
   endtask

   task automatic cmp_b();
      cmp("B", cb, nb, 32'(xb), 32'(yb), 32'(blb), 32'(hsb), 32'(vsb),
          32'(sxb), 32'(syb), 32'(adb), 32'(fsb), 32'(fcb));
   endtask

   initial begin
      int rb_at, rb_len;
      ca = '{hv:640, hfp:16, hsy:96, hbp:48, vv:480, vfp:10, vsy:2,
             vbp:33, sw:110, sh:96, sd:2};
      cb = '{hv:64, hfp:6, hsy:10, hbp:8, vv:40, vfp:3, vsy:2,
             vbp:5, sw:23, sh:17, sd:3};
      rst_a  = 1'b0;
      rst_b  = 1'b0;
      na     = 0;
      nb     = 0;
      rb_at  = int'($urandom_range(2000, 3000));
      rb_len = int'($urandom_range(1, 4));
      repeat (3) @(posedge clk);
      #1;
      cmp_a();
      cmp_b();
      rst_a = 1'b1;
      rst_b = 1'b1;
      for (int i = 0; i < 14000; i++) begin
         @(posedge clk);
         if (rst_a) na++;
         if (rst_b) nb++;
         #1;
         // A: DrawY=1, DrawX=300 -> 3-cycle async reset
         if (i == 1099) begin
            rst_a = 1'b0;
            na    = 0;
            #1;
            cmp_a();
         end
         if (i == 1102) rst_a = 1'b1;
         if (i == rb_at) begin
            rst_b = 1'b0;
            nb    = 0;
            #1;
            cmp_b();
         end
         if (i == rb_at + rb_len) rst_b = 1'b1;
         @(negedge clk);
         cmp_a();
         cmp_b();
      end
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_scan_gen.md
Name: vga_scan_gen

Overview:
- Upstream neighbour of the sprite ROM/palette display stages.
- Generates 640x480@60 VGA raster timing on vga_clk: pixel counters DrawX/DrawY, display-enable blank, and hs/vs syncs delayed to match the downstream pipeline.
- Also produces a registered, divider-free scaled source coordinate and ROM address for a SRC_W x SRC_H image stretched over the visible area, plus frame markers for animation logic.

Parameters:
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_VIS, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- SRC_W, 110, source image width; must satisfy 1 <= SRC_W <= H_VIS
- SRC_H, 96, source image height; must satisfy 1 <= SRC_H <= V_VIS
- ADDR_W, 14, ROM address width
- SYNC_DELAY, 2, pipeline cycles applied to hs/vs (ROM read + colour register); 0 allowed

Ports:
- vga_clk  in  1  pixel clock
- reset_n  in  1  asynchronous active-low reset
- DrawX  out  10  horizontal counter, 0..H_TOT-1 (H_TOT = 800)
- DrawY  out  10  vertical counter, 0..V_TOT-1 (V_TOT = 525)
- blank  out  1  display enable: 1 when DrawX<H_VIS and DrawY<V_VIS
- hs  out  1  horizontal sync, active low, delayed SYNC_DELAY cycles
- vs  out  1  vertical sync, active low, delayed SYNC_DELAY cycles
- src_x  out  10  floor(DrawX*SRC_W/H_VIS) when visible, else 0
- src_y  out  10  floor(DrawY*SRC_H/V_VIS) when DrawY<V_VIS, else 0
- rom_addr  out  ADDR_W  src_y*SRC_W + src_x
- frame_start  out  1  1 on the cycle DrawX=0 and DrawY=0
- frame_count  out  16  frames started since reset, wraps

Behaviour:
- Reset (async, reset_n=0): DrawX=DrawY=0, src_x=src_y=0, rom_addr=0, accumulators and row_base=0, frame_count=0, entire sync delay line=1 (hs=vs=1). blank=1 and frame_start=1, because both are decoded from counters at (0,0).
- Counters: DrawX increments every cycle. At H_TOT-1 it wraps to 0 and DrawY increments. At (H_TOT-1, V_TOT-1) both wrap to 0 and frame_count increments in the same edge, so the new count coincides with frame_start.
- Raw syncs:
  - hs_raw=0 for DrawX in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC), i.e. [656,752).
  - vs_raw=0 for DrawY in [V_VIS+V_FP, V_VIS+V_FP+V_SYNC), i.e. [490,492).
  - Both pass through a SYNC_DELAY-deep shift register; SYNC_DELAY=0 means direct combinational decode.
- blank and frame_start are undelayed and aligned with DrawX/DrawY; downstream stages delay colour themselves.
- Horizontal scaling (no multiply/divide):
  - acc_x holds (DrawX*SRC_W) mod H_VIS.
  - Advancing to the next visible pixel: t = acc_x + SRC_W. If t >= H_VIS then acc_x = t - H_VIS and src_x += 1; else acc_x = t.
  - When the next DrawX >= H_VIS or wraps to 0: acc_x=0, src_x=0.
- Vertical scaling: identical scheme on acc_y/src_y, stepped once per line at the line wrap.
  - row_base += SRC_W whenever src_y increments.
  - All three (acc_y, src_y, row_base) clear when the next DrawY >= V_VIS or the frame wraps.
- rom_addr = row_base + src_x, registered, same cycle as DrawX/DrawY/src_x (zero relative latency).
- Outside the visible area src_x/src_y/rom_addr are 0. Downstream masks with blank.
- Reset mid-frame: all state returns to reset values immediately; the delay line flushes to 1. On release, counting restarts at (0,0) and frame_count restarts at 0.
- Widths: acc_x needs ceil(log2(H_VIS+SRC_W)) bits; row_base and rom_addr use ADDR_W bits. SRC_W*SRC_H <= 2^ADDR_W is required (10560 <= 16384).

Test Plan:
- Reset held then released -> DrawX=DrawY=0, blank=1, frame_start=1, frame_count=0, hs=vs=1. DrawX reaches 5 five cycles after release.
- Run one line -> hs_raw low for DrawX 656..751. hs output low from DrawX 658 through 753 (SYNC_DELAY=2); blank=0 from DrawX 640; DrawY becomes 1 after DrawX=799.
- Run one frame -> vs low for lines 490..491 (delayed 2 cycles). frame_start pulses once per 420000 cycles; frame_count=1 at the second pulse.
- Scaling line 0 -> src_x=0 at DrawX=5, src_x=1 at DrawX=6, src_x=109 at DrawX=639. Compare every visible pixel against floor(DrawX*110/640).
- Scaling at DrawY=479, DrawX=639 -> src_y=95, rom_addr=10559. At DrawY=5, src_y=1 and rom_addr=110+src_x. At DrawX=640 everything returns to 0.
- Assert reset_n low at DrawX=300, DrawY=200 for 3 cycles -> outputs go to reset values asynchronously. After release the sequence matches the post-reset trace exactly.
